// File: rtl/tl_pkg.sv
// TileLink-UL channel definitions shared by the register bridge and its bench.
package tl_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SIZE_W   = 3;
    localparam int SOURCE_W = 8;
    localparam int SINK_W   = 1;
    localparam int MASK_W   = DATA_W / 8;

    localparam logic [2:0] A_GET             = 3'd4;
    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'($clog2(MASK_W));

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic                corrupt;
        logic [DATA_W-1:0]   data;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic                corrupt;
        logic [DATA_W-1:0]   data;
    } B_chan_bits_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic                corrupt;
        logic [DATA_W-1:0]   data;
    } C_chan_bits_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [SINK_W-1:0]   sink;
        logic                denied;
        logic                corrupt;
        logic [DATA_W-1:0]   data;
    } D_chan_bits_t;

    typedef struct packed {
        logic [SINK_W-1:0] sink;
    } E_chan_bits_t;

endpackage

// File: rtl/tl_slave_reg_bridge_if.sv
// Flat five-channel TileLink link between a TL master and the register bridge.
interface tl_slave_reg_bridge_if;
    import tl_pkg::*;

    logic         A_valid;
    logic         A_ready;
    A_chan_bits_t A_bits;
    logic         B_valid;
    logic         B_ready;
    B_chan_bits_t B_bits;
    logic         C_valid;
    logic         C_ready;
    C_chan_bits_t C_bits;
    logic         D_valid;
    logic         D_ready;
    D_chan_bits_t D_bits;
    logic         E_valid;
    logic         E_ready;
    E_chan_bits_t E_bits;

    modport slave (
        input  A_valid, A_bits, output A_ready,
        output B_valid, B_bits, input  B_ready,
        input  C_valid, C_bits, output C_ready,
        output D_valid, D_bits, input  D_ready,
        input  E_valid, E_bits, output E_ready
    );

    modport master (
        output A_valid, A_bits, input  A_ready,
        input  B_valid, B_bits, output B_ready,
        output C_valid, C_bits, input  C_ready,
        input  D_valid, D_bits, output D_ready,
        output E_valid, E_bits, input  E_ready
    );

endinterface

// File: rtl/tl_slave_reg_bridge.sv
// TL-UL slave to req/gnt/rvalid register bridge, one transaction in flight.
// Define TL_REG_BRIDGE_TIMEOUT_EN to abort stalled register accesses.
module tl_slave_reg_bridge
    import tl_pkg::*;
#(
    parameter int REG_ADDR_W  = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    tl_slave_reg_bridge_if.slave  tl,
    output logic                  reg_req_o,
    input  logic                  reg_gnt_i,
    output logic                  reg_we_o,
    output logic [REG_ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic [MASK_W-1:0]     reg_be_o,
    input  logic                  reg_rvalid_i,
    input  logic [DATA_W-1:0]     reg_rdata_i,
    input  logic                  reg_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

    state_e            state_q, state_d;
    A_chan_bits_t      a_q, a_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              denied_q, denied_d;
    logic              en_q;
    logic              a_ready;
    logic              accept;
    logic              supported;
    logic              get_like;
    logic              timeout;

    // en_q keeps A_ready low while reset is asserted
    assign a_ready  = (state_q == IDLE) && en_q;
    assign accept   = tl.A_valid && a_ready;
    assign get_like = a_q.opcode[2];

    always_comb begin
        supported = 1'b0;
        unique case (tl.A_bits.opcode)
            A_GET, A_PUT_FULL, A_PUT_PARTIAL: supported = 1'b1;
            default:                          supported = 1'b0;
        endcase
        if (tl.A_bits.size > MAX_SIZE) supported = 1'b0;
    end

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                           $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (state_q == REQ || state_q == WAIT) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            rdata_q  <= '0;
            denied_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            rdata_q  <= rdata_d;
            denied_q <= denied_d;
            en_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        rdata_d  = rdata_q;
        denied_d = denied_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = tl.A_bits;
                    rdata_d  = '0;
                    denied_d = ~supported;
                    state_d  = supported ? REQ : RSP;
                end
            end
            REQ: begin
                if (reg_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    denied_d = 1'b1;
                    state_d  = RSP;
                end
            end
            WAIT: begin
                if (reg_rvalid_i) begin
                    rdata_d  = reg_rdata_i;
                    denied_d = reg_err_i;
                    state_d  = RSP;
                end else if (timeout) begin
                    denied_d = 1'b1;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (tl.D_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tl.A_ready  = a_ready;
        tl.B_valid  = 1'b0;
        tl.B_bits   = '0;
        tl.C_ready  = 1'b1;
        tl.E_ready  = 1'b1;
        tl.D_valid  = 1'b0;
        tl.D_bits   = '0;
        reg_req_o   = 1'b0;
        reg_we_o    = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        reg_be_o    = '0;
        unique case (state_q)
            REQ: begin
                reg_req_o   = 1'b1;
                reg_we_o    = ~a_q.opcode[2];
                reg_addr_o  = a_q.address[REG_ADDR_W-1:0];
                reg_wdata_o = a_q.data;
                reg_be_o    = a_q.mask;
            end
            RSP: begin
                tl.D_valid        = 1'b1;
                tl.D_bits.opcode  = get_like ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                tl.D_bits.size    = a_q.size;
                tl.D_bits.source  = a_q.source;
                tl.D_bits.denied  = denied_q;
                tl.D_bits.corrupt = get_like && denied_q;
                tl.D_bits.data    = get_like ? rdata_q : '0;
            end
            default: ;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{tl.B_ready, tl.C_valid, tl.C_bits,
                         tl.E_valid, tl.E_bits, a_q.param, a_q.corrupt,
                         a_q.address[ADDR_W-1:REG_ADDR_W]};

endmodule

// File: tb/tb_tl_slave_reg_bridge.sv
// Directed bench for tl_slave_reg_bridge: Get/Put flows, backpressure, errors, reset.
// Timeout steps run only when TL_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_tl_slave_reg_bridge;
    import tl_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              reg_req, reg_gnt, reg_we, reg_rvalid, reg_err;
    logic [11:0]       reg_addr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;
    logic [MASK_W-1:0] reg_be;
    int                checks = 0;
    int                errors = 0;
    D_chan_bits_t      d_hold;

    tl_slave_reg_bridge_if bus ();

    tl_slave_reg_bridge #(.REG_ADDR_W(12), .TIMEOUT_CYC(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tl          (bus),
        .reg_req_o   (reg_req),
        .reg_gnt_i   (reg_gnt),
        .reg_we_o    (reg_we),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_be_o    (reg_be),
        .reg_rvalid_i(reg_rvalid),
        .reg_rdata_i (reg_rdata),
        .reg_err_i   (reg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic A_chan_bits_t mk(input logic [2:0] op,
                                        input logic [2:0] sz,
                                        input logic [7:0] src,
                                        input logic [31:0] addr,
                                        input logic [3:0] mask,
                                        input logic [31:0] data);
        A_chan_bits_t a;
        a = '0;
        a.opcode  = op;
        a.size    = sz;
        a.source  = src;
        a.address = addr;
        a.mask    = mask;
        a.data    = data;
        return a;
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic handshake_d();
        bus.D_ready = 1'b1;
        nxt();
        bus.D_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        reg_gnt = 0; reg_rvalid = 0; reg_rdata = '0; reg_err = 0;
        bus.A_valid = 0; bus.A_bits = '0; bus.B_ready = 0;
        bus.C_valid = 0; bus.C_bits = '0; bus.D_ready = 0;
        bus.E_valid = 0; bus.E_bits = '0;
        repeat (2) nxt();

        chk("rst_a_ready", 64'(bus.A_ready), 0);
        chk("rst_c_ready", 64'(bus.C_ready), 1);
        chk("rst_e_ready", 64'(bus.E_ready), 1);
        chk("rst_b_valid", 64'(bus.B_valid), 0);
        chk("rst_d_valid", 64'(bus.D_valid), 0);
        chk("rst_d_bits", 64'(bus.D_bits), 0);
        chk("rst_req", 64'(reg_req), 0);
        rst_n = 1'b1;
        nxt();
        chk("idle_a_ready", 64'(bus.A_ready), 1);

        // Get 0x104
        bus.A_valid = 1;
        bus.A_bits = mk(A_GET, 2, 3, 32'h104, 4'hF, 0);
        nxt();
        bus.A_valid = 0;
        chk("get_req", 64'(reg_req), 1);
        chk("get_we", 64'(reg_we), 0);
        chk("get_addr", 64'(reg_addr), 64'h104);
        chk("get_be", 64'(reg_be), 64'hF);
        chk("get_a_ready", 64'(bus.A_ready), 0);
        chk("get_dv_req", 64'(bus.D_valid), 0);
        reg_gnt = 1;
        nxt();
        reg_gnt = 0;
        chk("get_req_wait", 64'(reg_req), 0);
        chk("get_dv_wait", 64'(bus.D_valid), 0);
        reg_rvalid = 1; reg_rdata = 32'hDEADBEEF;
        nxt();
        reg_rvalid = 0;
        chk("get_dv", 64'(bus.D_valid), 1);
        chk("get_dop", 64'(bus.D_bits.opcode), 64'(D_ACCESS_ACK_DATA));
        chk("get_data", 64'(bus.D_bits.data), 64'hDEADBEEF);
        chk("get_src", 64'(bus.D_bits.source), 3);
        chk("get_size", 64'(bus.D_bits.size), 2);
        chk("get_denied", 64'(bus.D_bits.denied), 0);
        chk("get_corrupt", 64'(bus.D_bits.corrupt), 0);
        handshake_d();
        chk("get_done_dv", 64'(bus.D_valid), 0);
        chk("get_done_ar", 64'(bus.A_ready), 1);

        // PutPartialData, then a Get held pending behind D backpressure
        bus.A_valid = 1;
        bus.A_bits = mk(A_PUT_PARTIAL, 2, 5, 32'h008, 4'h3, 32'h12345678);
        nxt();
        chk("put_req", 64'(reg_req), 1);
        chk("put_we", 64'(reg_we), 1);
        chk("put_be", 64'(reg_be), 64'h3);
        chk("put_wdata", 64'(reg_wdata), 64'h12345678);
        chk("put_addr", 64'(reg_addr), 64'h8);
        bus.A_bits = mk(A_GET, 2, 7, 32'h020, 4'hF, 0);
        reg_gnt = 1;
        nxt();
        reg_gnt = 0;
        reg_rvalid = 1; reg_rdata = 32'hAAAA;
        nxt();
        reg_rvalid = 0;
        chk("put_dv", 64'(bus.D_valid), 1);
        chk("put_dop", 64'(bus.D_bits.opcode), 64'(D_ACCESS_ACK));
        chk("put_data", 64'(bus.D_bits.data), 0);
        chk("put_src", 64'(bus.D_bits.source), 5);
        chk("put_denied", 64'(bus.D_bits.denied), 0);
        d_hold = bus.D_bits;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("bp_dv", 64'(bus.D_valid), 1);
            chk("bp_bits", 64'(bus.D_bits), 64'(d_hold));
            chk("bp_a_ready", 64'(bus.A_ready), 0);
        end
        handshake_d();
        chk("bp_idle_dv", 64'(bus.D_valid), 0);
        chk("bp_idle_ar", 64'(bus.A_ready), 1);
        chk("bp_idle_req", 64'(reg_req), 0);
        nxt();
        bus.A_valid = 0;
        chk("next_req", 64'(reg_req), 1);
        chk("next_addr", 64'(reg_addr), 64'h20);

        // Get completing with reg_err
        reg_gnt = 1;
        nxt();
        reg_gnt = 0;
        reg_rvalid = 1; reg_rdata = 32'h55; reg_err = 1;
        nxt();
        reg_rvalid = 0; reg_err = 0;
        chk("err_dv", 64'(bus.D_valid), 1);
        chk("err_denied", 64'(bus.D_bits.denied), 1);
        chk("err_corrupt", 64'(bus.D_bits.corrupt), 1);
        chk("err_dop", 64'(bus.D_bits.opcode), 64'(D_ACCESS_ACK_DATA));
        chk("err_src", 64'(bus.D_bits.source), 7);
        chk("err_data", 64'(bus.D_bits.data), 64'h55);
        handshake_d();

        // AcquireBlock is not supported
        bus.A_valid = 1;
        bus.A_bits = mk(3'd6, 2, 9, 32'h30, 4'hF, 0);
        nxt();
        bus.A_valid = 0;
        chk("acq_req", 64'(reg_req), 0);
        chk("acq_dv", 64'(bus.D_valid), 1);
        chk("acq_denied", 64'(bus.D_bits.denied), 1);
        chk("acq_dop", 64'(bus.D_bits.opcode), 64'(D_ACCESS_ACK_DATA));
        chk("acq_corrupt", 64'(bus.D_bits.corrupt), 1);
        chk("acq_src", 64'(bus.D_bits.source), 9);
        handshake_d();

        // PutFullData wider than the data bus
        bus.A_valid = 1;
        bus.A_bits = mk(A_PUT_FULL, 3, 2, 32'h40, 4'hF, 1);
        nxt();
        bus.A_valid = 0;
        chk("big_req", 64'(reg_req), 0);
        chk("big_dv", 64'(bus.D_valid), 1);
        chk("big_denied", 64'(bus.D_bits.denied), 1);
        chk("big_dop", 64'(bus.D_bits.opcode), 64'(D_ACCESS_ACK));
        chk("big_corrupt", 64'(bus.D_bits.corrupt), 0);
        chk("big_size", 64'(bus.D_bits.size), 3);
        handshake_d();

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
        bus.A_valid = 1;
        bus.A_bits = mk(A_PUT_FULL, 2, 4, 32'h60, 4'hF, 7);
        nxt();
        bus.A_valid = 0;
        for (int i = 0; i < 16; i++) begin
            chk("to_req", 64'(reg_req), 1);
            nxt();
        end
        chk("to_req_off", 64'(reg_req), 0);
        chk("to_dv", 64'(bus.D_valid), 1);
        chk("to_denied", 64'(bus.D_bits.denied), 1);
        chk("to_corrupt", 64'(bus.D_bits.corrupt), 0);
        handshake_d();
`endif

        // Reset pulse while waiting for rvalid
        bus.A_valid = 1;
        bus.A_bits = mk(A_GET, 2, 1, 32'h50, 4'hF, 0);
        nxt();
        bus.A_valid = 0;
        reg_gnt = 1;
        nxt();
        reg_gnt = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_req", 64'(reg_req), 0);
        chk("mid_rst_dv", 64'(bus.D_valid), 0);
        chk("mid_rst_ar", 64'(bus.A_ready), 0);
        chk("mid_rst_c", 64'(bus.C_ready), 1);
        nxt();
        rst_n = 1;
        reg_rvalid = 1; reg_rdata = 32'h1;
        nxt();
        reg_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_dv", 64'(bus.D_valid), 0);
            chk("post_rst_req", 64'(reg_req), 0);
            nxt();
        end
        chk("post_rst_ar", 64'(bus.A_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
